// File: rtl/mem_burst_master.sv
// mem_burst_master: accepts single/burst read and write commands from a client
// and turns them into burst accesses on the mainMem port.
//
// Ports
//   clock, reset                      system clock, async active-high reset
//   req_valid/req_ready               command handshake
//   req_wr, req_addr, req_size        command: direction, byte address, length code
//   wdata/wdata_valid/wdata_ready     client write-word stream (buffered before issue)
//   rdata/rdata_valid                 read-word stream, no backpressure
//   done, err                         one-cycle pulses: completed / rejected command
//   mem_addr, mem_data_in,
//   mem_acc_size, mem_wren,
//   mem_enable                        mainMem request side
//   mem_data_out, mem_busy            mainMem response side
//
// Every output is driven straight from a flop; the next-state block computes the
// value each output must show in the following cycle. Buses are MSB-first [0:n].
// READ_LAT must be at least 1.

module mem_burst_master #(
   parameter int unsigned READ_LAT = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [0:31] req_addr,
   input  logic [0:1]  req_size,
   input  logic [0:31] wdata,
   input  logic        wdata_valid,
   output logic        wdata_ready,
   output logic [0:31] rdata,
   output logic        rdata_valid,
   output logic        done,
   output logic        err,
   output logic [0:31] mem_addr,
   output logic [0:31] mem_data_in,
   output logic [0:1]  mem_acc_size,
   output logic        mem_wren,
   output logic        mem_enable,
   input  logic [0:31] mem_data_out,
   input  logic        mem_busy
);

   typedef enum logic [2:0] {
      StIdle, StWfill, StWissue, StWburst, StRissue, StRwait, StRstream, StDone
   } state_e;

   localparam logic [7:0] LatLast = 8'(READ_LAT - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  lat_q, lat_d;
   logic        drain_q, drain_d;
   logic [0:31] addr_q, addr_d;
   logic [0:1]  size_q, size_d;
   logic [3:0]  n_last;
   logic        wbuf_we;
   logic [0:31] wbuf_q [16];

   logic        req_ready_q, req_ready_d;
   logic        wdata_ready_q, wdata_ready_d;
   logic [0:31] rdata_q, rdata_d;
   logic        rdata_valid_q, rdata_valid_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [0:31] mem_addr_q, mem_addr_d;
   logic [0:31] mem_data_in_q, mem_data_in_d;
   logic [0:1]  mem_acc_size_q, mem_acc_size_d;
   logic        mem_wren_q, mem_wren_d;
   logic        mem_enable_q;

   // Index of the last word of the latched burst (N-1).
   always_comb begin
      n_last = 4'd0;
      unique case (size_q)
         2'b00: n_last = 4'd0;
         2'b01: n_last = 4'd3;
         2'b10: n_last = 4'd7;
         2'b11: n_last = 4'd15;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      lat_d          = lat_q;
      drain_d        = drain_q;
      addr_d         = addr_q;
      size_d         = size_q;
      wbuf_we        = 1'b0;
      req_ready_d    = 1'b0;
      wdata_ready_d  = 1'b0;
      rdata_d        = rdata_q;
      rdata_valid_d  = 1'b0;
      done_d         = 1'b0;
      err_d          = 1'b0;
      mem_addr_d     = mem_addr_q;
      mem_data_in_d  = mem_data_in_q;
      mem_acc_size_d = mem_acc_size_q;
      mem_wren_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               if (req_addr[30:31] != 2'b00) begin
                  err_d = 1'b1;
               end else begin
                  addr_d      = req_addr;
                  size_d      = req_size;
                  cnt_d       = 4'd0;
                  req_ready_d = 1'b0;
                  if (req_wr) begin
                     state_d       = StWfill;
                     wdata_ready_d = 1'b1;
                  end else begin
                     state_d = StRissue;
                  end
               end
            end
         end
         StWfill: begin
            wdata_ready_d = 1'b1;
            if (wdata_valid && wdata_ready_q) begin
               wbuf_we = 1'b1;
               if (cnt_q == n_last) begin
                  cnt_d         = 4'd0;
                  wdata_ready_d = 1'b0;
                  state_d       = StWissue;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         StWissue: begin
            if (!mem_busy) begin
               state_d        = StWburst;
               mem_wren_d     = 1'b1;
               mem_addr_d     = addr_q;
               mem_acc_size_d = size_q;
               mem_data_in_d  = wbuf_q[0];
            end
         end
         StWburst: begin
            // cnt_q is the index of the word on mem_data_in this cycle.
            if (cnt_q == n_last) begin
               state_d = StDone;
               done_d  = 1'b1;
               cnt_d   = 4'd0;
            end else begin
               cnt_d         = cnt_q + 4'd1;
               mem_wren_d    = 1'b1;
               mem_data_in_d = wbuf_q[cnt_q + 4'd1];
            end
         end
         StRissue: begin
            // The address cycle is the first RWAIT cycle, when the flops show it.
            if (!mem_busy) begin
               state_d        = StRwait;
               mem_addr_d     = addr_q;
               mem_acc_size_d = size_q;
               lat_d          = 8'd0;
            end
         end
         StRwait: begin
            if (lat_q == LatLast) begin
               state_d = StRstream;
               cnt_d   = 4'd0;
               drain_d = 1'b0;
            end else begin
               lat_d = lat_q + 8'd1;
            end
         end
         StRstream: begin
            // One extra cycle after the last sample lets the last rdata show
            // before done.
            if (drain_q) begin
               state_d = StDone;
               done_d  = 1'b1;
               drain_d = 1'b0;
            end else begin
               rdata_d       = mem_data_out;
               rdata_valid_d = 1'b1;
               if (cnt_q == n_last) begin
                  drain_d = 1'b1;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         StDone: begin
            state_d     = StIdle;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         cnt_q          <= 4'd0;
         lat_q          <= 8'd0;
         drain_q        <= 1'b0;
         addr_q         <= '0;
         size_q         <= 2'b00;
         req_ready_q    <= 1'b0;
         wdata_ready_q  <= 1'b0;
         rdata_q        <= '0;
         rdata_valid_q  <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         mem_addr_q     <= '0;
         mem_data_in_q  <= '0;
         mem_acc_size_q <= 2'b00;
         mem_wren_q     <= 1'b0;
         mem_enable_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         lat_q          <= lat_d;
         drain_q        <= drain_d;
         addr_q         <= addr_d;
         size_q         <= size_d;
         req_ready_q    <= req_ready_d;
         wdata_ready_q  <= wdata_ready_d;
         rdata_q        <= rdata_d;
         rdata_valid_q  <= rdata_valid_d;
         done_q         <= done_d;
         err_q          <= err_d;
         mem_addr_q     <= mem_addr_d;
         mem_data_in_q  <= mem_data_in_d;
         mem_acc_size_q <= mem_acc_size_d;
         mem_wren_q     <= mem_wren_d;
         mem_enable_q   <= 1'b1;
      end
   end

   // Write buffer needs no reset: it is always filled before it is read.
   always_ff @(posedge clock) begin
      if (wbuf_we) begin
         wbuf_q[cnt_q] <= wdata;
      end
   end

   assign req_ready    = req_ready_q;
   assign wdata_ready  = wdata_ready_q;
   assign rdata        = rdata_q;
   assign rdata_valid  = rdata_valid_q;
   assign done         = done_q;
   assign err          = err_q;
   assign mem_addr     = mem_addr_q;
   assign mem_data_in  = mem_data_in_q;
   assign mem_acc_size = mem_acc_size_q;
   assign mem_wren     = mem_wren_q;
   assign mem_enable   = mem_enable_q;

endmodule
